zeta_table_gen: RTL and testbench

//  Initiator for the gpow start/done/busy handshake. On one start it fills a twiddle RAM with
//  wr_data[i] = ZETA^e(i) mod 8380417, for i = 0..2^LOGN-1, with one gpow request per entry.
//  e(i) = bitrev_LOGN(i) when BITREV=1, else e(i) = i.

---
 rtl/zeta_table_gen_if.sv | 26 ++
 rtl/zeta_table_gen.sv | 152 +++++++++++++++
 tb/tb_zeta_table_gen.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zeta_table_gen_if.sv
// gpow request/response and twiddle-RAM write port between the table generator and its neighbours.
// master = table generator side; slave = gpow unit and twiddle memory side.
interface zeta_table_gen_if #(
  parameter int WIDTH = 24,
  parameter int LOGN  = 8
);
  logic             gp_start;
  logic [WIDTH-1:0] gp_a;
  logic [WIDTH-1:0] gp_b;
  logic             gp_done;
  logic             gp_busy;
  logic [WIDTH-1:0] gp_res;
  logic             wr_en;
  logic [LOGN-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output gp_start, gp_a, gp_b, wr_en, wr_addr, wr_data,
    input  gp_done, gp_busy, gp_res
  );

  modport slave (
    input  gp_start, gp_a, gp_b, wr_en, wr_addr, wr_data,
    output gp_done, gp_busy, gp_res
  );
endinterface

// File: rtl/zeta_table_gen.sv
// Fills the twiddle RAM with ZETA^e(k) mod Q, one gpow request per entry (gpow latency + 3 cycles each).
// Stalls on the gpow start/done level handshake; abort drains gpow before returning to idle.
module zeta_table_gen #(
  parameter int WIDTH  = 24,
  parameter int LOGN   = 8,
  parameter int ZETA   = 1753,
  parameter int BITREV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic aborted,
  zeta_table_gen_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_WRITE, S_RELEASE, S_FINISH, S_DRAIN
  } state_t;

  state_t           state, state_nxt;
  logic [LOGN-1:0]  k, k_nxt;
  logic             busy_nxt, done_nxt, aborted_nxt;
  logic             gp_start, gp_start_nxt;
  logic [WIDTH-1:0] gp_b, gp_b_nxt;
  logic             wr_en, wr_en_nxt;
  logic [LOGN-1:0]  wr_addr, wr_addr_nxt;
  logic [WIDTH-1:0] wr_data, wr_data_nxt;

  function automatic logic [LOGN-1:0] exp_of(input logic [LOGN-1:0] idx);
    logic [LOGN-1:0] r;
    r = idx;
    if (BITREV != 0) begin
      for (int b = 0; b < LOGN; b++) r[b] = idx[LOGN-1-b];
    end
    return r;
  endfunction

  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    aborted_nxt  = 1'b0;
    gp_start_nxt = gp_start;
    gp_b_nxt     = gp_b;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;

    unique case (state)
      S_IDLE: begin
        // gp_done still high means gpow has not released the previous request yet
        if (start && !bus.gp_done) begin
          k_nxt     = '0;
          busy_nxt  = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (abort) begin
          gp_start_nxt = 1'b0;
          state_nxt    = S_DRAIN;
        end else begin
          gp_b_nxt     = WIDTH'(exp_of(k));
          gp_start_nxt = 1'b1;
          state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          gp_start_nxt = 1'b0;
          state_nxt    = S_DRAIN;
        end else if (bus.gp_done) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        gp_start_nxt = 1'b0;
        if (abort) begin
          state_nxt = S_DRAIN;
        end else begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = k;
          wr_data_nxt = bus.gp_res;
          state_nxt   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (abort) begin
          state_nxt = S_DRAIN;
        end else if (!bus.gp_done) begin
          if (&k) begin
            state_nxt = S_FINISH;
          end else begin
            k_nxt     = k + 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_FINISH: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (!bus.gp_done && !bus.gp_busy) begin
          aborted_nxt = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      k        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      gp_start <= 1'b0;
      gp_b     <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      aborted  <= aborted_nxt;
      gp_start <= gp_start_nxt;
      gp_b     <= gp_b_nxt;
      wr_en    <= wr_en_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
    end
  end

  assign bus.gp_start = gp_start;
  assign bus.gp_a     = WIDTH'(ZETA);
  assign bus.gp_b     = gp_b;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;

endmodule

// File: tb/tb_zeta_table_gen.sv
// Bench for zeta_table_gen: two instances (bit-reversed LOGN=8, natural LOGN=9) each driving a behavioural gpow.
module tb_zeta_table_gen;
  localparam longint Q    = 8380417;
  localparam longint ZETA = 1753;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, abort0, busy0, done0, aborted0;
  logic start1, abort1, busy1, done1, aborted1;

  zeta_table_gen_if #(.WIDTH(24), .LOGN(8)) i0();
  zeta_table_gen_if #(.WIDTH(24), .LOGN(9)) i1();

  zeta_table_gen #(.WIDTH(24), .LOGN(8), .ZETA(1753), .BITREV(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .busy(busy0), .done(done0), .aborted(aborted0), .bus(i0));

  zeta_table_gen #(.WIDTH(24), .LOGN(9), .ZETA(1753), .BITREV(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .aborted(aborted1), .bus(i1));

  // behavioural gpow: accepts when idle, random latency, done held until start drops
  logic        gs[2], gd[2], gbz[2];
  logic [23:0] gexp[2], gres[2];
  int          gcnt[2];

  assign gs[0] = i0.gp_start;  assign gexp[0] = i0.gp_b;
  assign gs[1] = i1.gp_start;  assign gexp[1] = i1.gp_b;
  assign i0.gp_done = gd[0];   assign i0.gp_busy = gbz[0];  assign i0.gp_res = gres[0];
  assign i1.gp_done = gd[1];   assign i1.gp_busy = gbz[1];  assign i1.gp_res = gres[1];

  function automatic longint powmod(longint b, longint e);
    longint r = 1;
    b = b % Q;
    while (e > 0) begin
      if (e[0]) r = (r * b) % Q;
      b = (b * b) % Q;
      e = e >> 1;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 2; j++) begin
        gd[j] <= 1'b0; gbz[j] <= 1'b0; gres[j] <= '0; gcnt[j] <= 0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!gbz[j] && !gd[j]) begin
          if (gs[j]) begin
            gbz[j]  <= 1'b1;
            gcnt[j] <= $urandom_range(5, 40);
            gres[j] <= 24'(powmod(ZETA, longint'(gexp[j])));
          end
        end else if (!gd[j]) begin
          if (gcnt[j] <= 1) gd[j] <= 1'b1;
          else gcnt[j] <= gcnt[j] - 1;
        end else if (!gs[j]) begin
          gd[j]  <= 1'b0;
          gbz[j] <= 1'b0;
        end
      end
    end
  end

  // reference: powers of ZETA by repeated multiplication, indexed by exponent
  longint zp[512];
  function automatic int erev(int i, int logn, bit br);
    int r = 0;
    if (!br) return i;
    for (int b = 0; b < logn; b++) if (((i >> b) & 1) != 0) r = r | (1 << (logn - 1 - b));
    return r;
  endfunction

  logic [8:0]  qa0[$], qa1[$];
  logic [23:0] qd0[$], qd1[$];
  int dn0, dn1, viol0, busy_bad0, busy_bad1, ab_bad0;
  logic pgs0, pbusy0, pbusy1;

  always @(negedge clk) begin
    if (i0.wr_en) begin qa0.push_back(9'(i0.wr_addr)); qd0.push_back(i0.wr_data); end
    if (i1.wr_en) begin qa1.push_back(i1.wr_addr); qd1.push_back(i1.wr_data); end
    if (done0) begin dn0++; if (busy0 !== 1'b0 || pbusy0 !== 1'b1) busy_bad0++; end
    if (done1) begin dn1++; if (busy1 !== 1'b0 || pbusy1 !== 1'b1) busy_bad1++; end
    if (i0.gp_start && !pgs0 && i0.gp_done) viol0++;
    if (aborted0 && (i0.gp_done || i0.gp_busy)) ab_bad0++;
    pgs0 = i0.gp_start; pbusy0 = busy0; pbusy1 = busy1;
  end

  // mismatches in entries [base, base+N) against the reference, addresses must run 0..N-1
  function automatic int tbl_err(int inst, int base);
    int n = inst ? 512 : 256;
    int errs = 0;
    int sz = inst ? qa1.size() : qa0.size();
    if (sz < base + n) return n;
    for (int i = 0; i < n; i++) begin
      int a = inst ? int'(qa1[base+i]) : int'(qa0[base+i]);
      longint d = inst ? longint'(qd1[base+i]) : longint'(qd0[base+i]);
      if (a != i || d != zp[erev(i, inst ? 9 : 8, inst ? 1'b0 : 1'b1)]) errs++;
    end
    return errs;
  endfunction

  int tests = 0, fails = 0;

  task automatic pulse_start(input int inst);
    @(negedge clk);
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done0(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      if (done0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start0 = 0; abort0 = 0; start1 = 0; abort1 = 0;
    #3;
    tests++; if ({busy0, done0, aborted0, i0.gp_start, i0.wr_en} !== 5'b0) begin
      fails++; $display("FAIL reset_ctl0: got %b want 00000", {busy0, done0, aborted0, i0.gp_start, i0.wr_en});
    end
    tests++; if (i0.gp_a !== 24'd1753) begin
      fails++; $display("FAIL reset_gp_a: got %0d want 1753", i0.gp_a);
    end
    tests++; if ({i1.gp_b, i1.wr_addr, i1.wr_data, busy1, i1.gp_start} !== 59'b0) begin
      fails++; $display("FAIL reset_bus1: got %h want 0", {i1.gp_b, i1.wr_addr, i1.wr_data, busy1, i1.gp_start});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_natural;
    bit ok = 1'b0;
    qa1.delete(); qd1.delete(); dn1 = 0; busy_bad1 = 0;
    pulse_start(1);
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      if (done1) begin ok = 1'b1; break; end
    end
    repeat (30) @(negedge clk);
    tests++; if (!ok) begin fails++; $display("FAIL nat_done: got no done want done within budget"); end
    tests++; if (qa1.size() != 512) begin fails++; $display("FAIL nat_count: got %0d want 512", qa1.size()); end
    tests++; if (tbl_err(1, 0) != 0) begin fails++; $display("FAIL nat_table: got %0d bad want 0", tbl_err(1, 0)); end
    if (qd1.size() >= 257) begin
      tests++; if (qd1[0] !== 24'd1 || qd1[1] !== 24'd1753) begin
        fails++; $display("FAIL nat_addr01: got %0d,%0d want 1,1753", qd1[0], qd1[1]);
      end
      tests++; if (qd1[2] !== 24'd3073009 || qd1[256] !== 24'd8380416) begin
        fails++; $display("FAIL nat_addr2_256: got %0d,%0d want 3073009,8380416", qd1[2], qd1[256]);
      end
    end
    tests++; if (dn1 != 1 || busy_bad1 != 0) begin
      fails++; $display("FAIL nat_done_busy: got done=%0d busybad=%0d want 1,0", dn1, busy_bad1);
    end
  endtask

  task automatic test_fill_bitrev;
    bit ok;
    qa0.delete(); qd0.delete(); dn0 = 0; busy_bad0 = 0; viol0 = 0;
    pulse_start(0);
    wait_done0(ok);
    repeat (30) @(negedge clk);
    tests++; if (!ok || qa0.size() != 256) begin
      fails++; $display("FAIL br_count: got ok=%0d n=%0d want 1,256", ok, qa0.size());
    end
    tests++; if (tbl_err(0, 0) != 0) begin fails++; $display("FAIL br_table: got %0d bad want 0", tbl_err(0, 0)); end
    if (qd0.size() >= 129) begin
      tests++; if (qd0[0] !== 24'd1 || qd0[1] !== 24'd4808194 || qd0[128] !== 24'd1753) begin
        fails++; $display("FAIL br_points: got %0d,%0d,%0d want 1,4808194,1753", qd0[0], qd0[1], qd0[128]);
      end
    end
    tests++; if (dn0 != 1 || busy_bad0 != 0) begin
      fails++; $display("FAIL br_done_busy: got done=%0d busybad=%0d want 1,0", dn0, busy_bad0);
    end
  endtask

  task automatic test_abort_wait;
    int wr = 0, late = 0;
    bit seen = 1'b0, reached = 1'b0;
    logic busy_at;
    qa0.delete(); qd0.delete(); dn0 = 0; ab_bad0 = 0;
    pulse_start(0);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (i0.wr_en) wr++;
      if (wr == 5 && i0.gp_start && !i0.gp_done) begin reached = 1'b1; break; end
    end
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    tests++; if (!reached || i0.gp_start !== 1'b0) begin
      fails++; $display("FAIL abort_gp_start: got reached=%0d gp_start=%b want 1,0", reached, i0.gp_start);
    end
    busy_at = 1'bx;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (i0.wr_en) late++;
      if (aborted0) begin seen = 1'b1; busy_at = busy0; break; end
    end
    repeat (20) @(negedge clk);
    tests++; if (!seen || busy_at !== 1'b0 || ab_bad0 != 0) begin
      fails++; $display("FAIL abort_pulse: got seen=%0d busy=%b early=%0d want 1,0,0", seen, busy_at, ab_bad0);
    end
    tests++; if (late != 0 || qa0.size() != 5 || dn0 != 0) begin
      fails++; $display("FAIL abort_writes: got late=%0d n=%0d done=%0d want 0,5,0", late, qa0.size(), dn0);
    end
  endtask

  task automatic test_back_to_back;
    int nd = 0;
    qa0.delete(); qd0.delete(); viol0 = 0;
    @(negedge clk);
    start0 = 1'b1;
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      if (done0) nd++;
      if (nd == 2) break;
    end
    start0 = 1'b0;
    repeat (60) @(negedge clk);
    tests++; if (nd != 2 || qa0.size() != 512) begin
      fails++; $display("FAIL b2b_count: got done=%0d n=%0d want 2,512", nd, qa0.size());
    end
    tests++; if (tbl_err(0, 0) != 0 || tbl_err(0, 256) != 0) begin
      fails++; $display("FAIL b2b_table: got %0d,%0d bad want 0,0", tbl_err(0, 0), tbl_err(0, 256));
    end
    tests++; if (viol0 != 0 || busy0 !== 1'b0) begin
      fails++; $display("FAIL b2b_handshake: got viol=%0d busy=%b want 0,0", viol0, busy0);
    end
  endtask

  task automatic test_reset_mid;
    int wr = 0;
    bit ok;
    qa0.delete(); qd0.delete();
    pulse_start(0);
    for (int c = 0; c < 8000 && wr < 100; c++) begin
      @(negedge clk);
      if (i0.wr_en) wr++;
    end
    #2 rst = 1'b1;
    #1;
    tests++; if ({busy0, done0, aborted0, i0.gp_start, i0.wr_en, i0.gp_b, i0.wr_addr, i0.wr_data} !== 61'b0
                 || i0.gp_a !== 24'd1753 || wr != 100) begin
      fails++; $display("FAIL rst_mid: got %h gp_a=%0d wr=%0d want 0,1753,100",
                        {busy0, done0, aborted0, i0.gp_start, i0.wr_en, i0.gp_b, i0.wr_addr, i0.wr_data}, i0.gp_a, wr);
    end
    @(negedge clk);
    rst = 1'b0;
    qa0.delete(); qd0.delete();
    pulse_start(0);
    wait_done0(ok);
    repeat (5) @(negedge clk);
    tests++; if (!ok || tbl_err(0, 0) != 0 || qa0.size() != 256) begin
      fails++; $display("FAIL rst_refill: got ok=%0d n=%0d bad=%0d want 1,256,0", ok, qa0.size(), tbl_err(0, 0));
    end
  endtask

  task automatic test_abort_done;
    int wr = 0, late = 0;
    bit seen = 1'b0, hit = 1'b0;
    logic pg;
    qa0.delete(); qd0.delete(); dn0 = 0;
    pulse_start(0);
    for (int c = 0; c < 2000 && wr < 3; c++) begin
      @(negedge clk);
      if (i0.wr_en) wr++;
    end
    pg = i0.gp_done;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (i0.gp_done && !pg) begin hit = 1'b1; break; end
      pg = i0.gp_done;
    end
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (i0.wr_en) late++;
      if (aborted0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    tests++; if (!hit || !seen || late != 0) begin
      fails++; $display("FAIL abort_done: got hit=%0d aborted=%0d wr=%0d want 1,1,0", hit, seen, late);
    end
    tests++; if (qa0.size() != 3 || dn0 != 0 || busy0 !== 1'b0) begin
      fails++; $display("FAIL abort_done_state: got n=%0d done=%0d busy=%b want 3,0,0", qa0.size(), dn0, busy0);
    end
  endtask

  initial begin
    zp[0] = 1;
    for (int j = 1; j < 512; j++) zp[j] = (zp[j-1] * ZETA) % Q;
    pgs0 = 0; pbusy0 = 0; pbusy1 = 0;
    dn0 = 0; dn1 = 0; viol0 = 0; busy_bad0 = 0; busy_bad1 = 0; ab_bad0 = 0;
    test_reset();
    test_fill_natural();
    test_fill_bitrev();
    test_abort_wait();
    test_back_to_back();
    test_reset_mid();
    test_abort_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
